keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
- Upstream front end for the whack-a-mole game core (`button_led_buzzer`). It drives the 4x4 matrix keypad columns and samples the rows.
- It debounces presses and hands the game core one clean event per physical press: a 4-bit key code plus a one-cycle valid strobe, and a held level.
- It replaces raw `row`/`col` handling inside the game logic.

Parameters:
- SCAN_DIV, 50000, clk cycles per scan tick (1 ms at 50 MHz). Minimum 2.
- DEBOUNCE_TICKS, 20, consecutive matching ticks needed to accept a press or a release. Minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- row  input  4  keypad row lines, active-low, pulled up externally; asynchronous to clk.
- col  output  4  column drive, active-low one-cold.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_down  output  1  high from acceptance until the release is accepted.

Behaviour:
- Synchronous, active-high reset. On rst:
  - col = 4'b1110; key_code = 0; key_valid = 0; key_down = 0.
  - state = SCAN; prescaler, debounce counter and column index all = 0.
  - rst mid-press discards everything. No key_valid is issued for a press that was in progress.
- Input sync: row passes through a 2-flop synchronizer (row_s). All decisions use row_s only.
- Prescaler: counts 0..SCAN_DIV-1 and produces `tick` on the cycle where count == SCAN_DIV-1. The prescaler runs free in all states.
- Row index: row_idx = position of the single 0 bit in row_s (row[0] -> 0).
  - "single" means exactly one bit is 0.
  - 4'b1111 means none.
  - Two or more 0 bits means multi; multi is treated as none.
- Column index: col_idx = position of the 0 bit in col.
- States and transitions (evaluated only on tick; between ticks all state holds):
  - SCAN:
    - If row_s is single: latch cand = {row_idx, col_idx}, keep col frozen, cnt = 1, go to DEBOUNCE.
    - Otherwise: rotate col (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - DEBOUNCE:
    - If row_s is single and its row_idx equals cand: cnt = cnt + 1. When cnt reaches DEBOUNCE_TICKS, go to HELD and, on the next clk cycle, set key_code = cand, key_valid = 1 (that cycle only) and key_down = 1.
    - Any other row_s: cnt = 0, rotate col, go to SCAN. No output change.
  - HELD:
    - col stays frozen.
    - If row_s == 4'b1111: cnt = cnt + 1. When cnt reaches DEBOUNCE_TICKS, set key_down = 0, cnt = 0, rotate col, go to SCAN.
    - Any non-idle row_s (including a second key in the same column): cnt = 0 and stay in HELD.
    - No auto-repeat and no second key_valid while in HELD.
- Latency: measured from the first tick that sees a stable single press on the driven column, key_valid rises exactly (DEBOUNCE_TICKS-1)*SCAN_DIV + 1 clk cycles later.
- Worst-case detection adds up to 4 ticks of scan rotation plus 2 cycles of synchronizer delay.
- key_code holds its last value until the next accepted press. It remains valid after key_down falls.
- Width rules: cnt is sized for DEBOUNCE_TICKS and saturates (never wraps). The prescaler wraps to 0 after SCAN_DIV-1.

Test Plan (bench: SCAN_DIV=4, DEBOUNCE_TICKS=3; keypad model drives row[r]=0 while the pressed key's column is 0, else 1):
- Reset behaviour: assert rst for 3 cycles -> col=1110, key_code=0, key_valid=0, key_down=0. With no press, col cycles 1110, 1101, 1011, 0111 every 4 clk.
- Clean press: press row 2 / col 1 and hold -> exactly one key_valid pulse with key_code=4'b1001, key_down=1. Release -> key_down=0 after 3 idle ticks and col resumes rotating.
- Bounce rejection: press row 0 / col 3, toggling every 5 clk for 40 clk, then stable -> no key_valid during bouncing; one key_valid with key_code=4'b0011 after stable for 3 ticks.
- Second key while held: hold row 1 / col 0, then also press row 3 / col 0 -> no additional key_valid. key_down stays 1 until both are released for 3 ticks.
- Multi-row press in the scanned column: press rows 1 and 2 in the same column simultaneously -> no key_valid and col keeps rotating.
- Reset mid-debounce: assert rst at cnt=2 while pressing row 3 / col 2 -> outputs return to reset values, with no key_valid emitted in that attempt.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with tick-based debounce of press and release.
// Emits one key_valid pulse per accepted press, plus a held level in key_down.
module keypad_scan_debounce #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_meta_q, row_s_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    col_q, col_d, col_rot;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;

  logic          tick;
  logic          row_single, row_idle, row_match;
  logic [1:0]    row_idx, col_idx;
  logic          accept, release_ev;

  // Two-flop synchronizer: row is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_comb begin
    row_single = 1'b0;
    row_idx    = 2'd0;
    case (row_s_q)
      4'b1110: begin row_single = 1'b1; row_idx = 2'd0; end
      4'b1101: begin row_single = 1'b1; row_idx = 2'd1; end
      4'b1011: begin row_single = 1'b1; row_idx = 2'd2; end
      4'b0111: begin row_single = 1'b1; row_idx = 2'd3; end
      default: begin row_single = 1'b0; row_idx = 2'd0; end
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign row_idle  = (row_s_q == 4'b1111);
  assign row_match = row_single && (row_idx == cand_q[3:2]);
  assign col_rot   = {col_q[2:0], col_q[3]};
  // Saturating increment so the counter can never wrap back into range.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  assign accept     = tick && (state_q == DEBOUNCE) && row_match && (cnt_inc == CNT_MAX);
  assign release_ev = tick && (state_q == HELD) && row_idle && (cnt_inc == CNT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  // Next-state and datapath updates; everything holds between ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    col_d   = col_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_single) begin
            cand_d  = {row_idx, col_idx};
            cnt_d   = CNT_ONE;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_rot;
          end
        end
        DEBOUNCE: begin
          if (row_match) begin
            if (cnt_inc == CNT_MAX) begin
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_rot;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (row_idle) begin
            if (cnt_inc == CNT_MAX) begin
              cnt_d   = '0;
              col_d   = col_rot;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      endcase
    end
  end

  // Output logic: outputs are registered, so they appear one cycle after the tick.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (accept) begin
      key_code_d  = cand_q;
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
    end else if (release_ev) begin
      key_down_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a queue-based key event scoreboard.
// A keypad model pulls a row low while a pressed key's column is driven low.
module tb_keypad_scan_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [3:0][3:0] press = '0;  // press[r][c]
  logic [3:0]      exp_q[$];
  int              errors = 0;
  int              checks = 0;
  int              pulses = 0;

  keypad_scan_debounce #(
    .SCAN_DIV(4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(press[r] & ~col);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_down(input logic lvl, input int bound, input string name);
    int n = 0;
    while (key_down !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, {7'd0, key_down}, {7'd0, lvl});
  endtask

  // Returns on the negedge right after col switches to target (prescaler phase 0).
  task automatic wait_col_edge(input logic [3:0] target, input int bound, input string name);
    logic [3:0] prev;
    logic       found = 1'b0;
    for (int n = 0; n < bound; n++) begin
      prev = col;
      @(negedge clk);
      if (col == target && prev != target) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {7'd0, found}, 8'd1);
  endtask

  // Monitor: every key_valid pulse must match the oldest expected key.
  initial begin
    logic [3:0] exp_code;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got key_code %0h with key_valid=1, required no pulse", key_code);
        end else begin
          exp_code = exp_q.pop_front();
          check("valid_key_code", {4'd0, key_code}, {4'd0, exp_code});
          check("valid_key_down", {7'd0, key_down}, 8'd1);
        end
      end
    end
  end

  initial begin
    logic [3:0] rot_exp[4];
    logic [3:0] prev_col;
    int         changes;
    rot_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", {4'd0, col}, 8'h0E);
    check("rst_key_code", {4'd0, key_code}, 8'h00);
    check("rst_key_valid", {7'd0, key_valid}, 8'h00);
    check("rst_key_down", {7'd0, key_down}, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("idle_rotate", {4'd0, col}, {4'd0, rot_exp[k]});
    end

    // Clean press row 2 / col 1, aligned to the column becoming active
    wait_col_edge(4'b1101, 40, "clean_col_align");
    press[2][1] = 1'b1;
    exp_q.push_back(4'b1001);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("clean_not_yet_down", {7'd0, key_down}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("clean_down_at_latency", {7'd0, key_down}, 8'h01);
    repeat (20) @(posedge clk);
    @(negedge clk);
    press[2][1] = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("clean_still_down", {7'd0, key_down}, 8'h01);
    @(posedge clk);
    @(negedge clk);
    check("clean_released", {7'd0, key_down}, 8'h00);
    check("clean_col_resumes", {4'd0, col}, 8'h0B);
    check("clean_code_kept", {4'd0, key_code}, 8'h09);

    // Bounce row 0 / col 3: toggle every 5 clk for 40 clk, then stable
    for (int i = 0; i < 8; i++) begin
      press[0][3] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    press[0][3] = 1'b1;
    exp_q.push_back(4'b0011);
    wait_down(1'b1, 100, "bounce_accepted");
    repeat (10) @(negedge clk);
    press[0][3] = 1'b0;
    wait_down(1'b0, 40, "bounce_released");

    // Second key in the same column while held
    press[1][0] = 1'b1;
    exp_q.push_back(4'b0100);
    wait_down(1'b1, 100, "second_first_down");
    press[3][0] = 1'b1;
    repeat (30) @(negedge clk);
    press[1][0] = 1'b0;
    repeat (30) @(negedge clk);
    check("second_still_held", {7'd0, key_down}, 8'h01);
    press[3][0] = 1'b0;
    repeat (10) @(negedge clk);
    check("second_release_min", {7'd0, key_down}, 8'h01);
    wait_down(1'b0, 10, "second_released");

    // Two rows in one column: rejected, scan keeps rotating
    press[1][2] = 1'b1;
    press[2][2] = 1'b1;
    changes  = 0;
    prev_col = col;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col != prev_col) changes++;
      prev_col = col;
    end
    check("multi_col_changes", 8'(changes), 8'd10);
    check("multi_no_down", {7'd0, key_down}, 8'h00);
    press[1][2] = 1'b0;
    press[2][2] = 1'b0;

    // Reset while debounce counter is at 2 on row 3 / col 2
    wait_col_edge(4'b1011, 40, "rstmid_col_align");
    press[3][2] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstmid_col", {4'd0, col}, 8'h0E);
    check("rstmid_key_code", {4'd0, key_code}, 8'h00);
    check("rstmid_key_valid", {7'd0, key_valid}, 8'h00);
    check("rstmid_key_down", {7'd0, key_down}, 8'h00);
    press[3][2] = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rstmid_no_down", {7'd0, key_down}, 8'h00);
    check("rstmid_code_cleared", {4'd0, key_code}, 8'h00);

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    check("total_pulses", 8'(pulses), 8'd3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
